// File: rtl/iterative_shifter_if.sv
// Start/busy/done handshake and operand/result bus of the iterative shifter.
// The controller drives the master side, the shift unit is the slave.
interface iterative_shifter_if #(
    parameter int unsigned WIDTH = 32
);
    localparam int unsigned SHAMT_W = $clog2(WIDTH);

    logic               Start;
    logic [WIDTH-1:0]   NumIn;
    logic [SHAMT_W-1:0] ShAmt;
    logic [1:0]         Mode;
    logic               Busy;
    logic               Done;
    logic [WIDTH-1:0]   NumOut;

    modport master (
        output Start, NumIn, ShAmt, Mode,
        input  Busy, Done, NumOut
    );

    modport slave (
        input  Start, NumIn, ShAmt, Mode,
        output Busy, Done, NumOut
    );
endinterface

// File: rtl/iterative_shifter.sv
// Multi-cycle SLL/SRL/SRA/ROTR unit that moves at most STEP bits per clock,
// trading latency for a small shifter in the MIPS ALU shift path.
module iterative_shifter #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned STEP  = 4
) (
    input  logic Clk,
    input  logic Rst_n,
    iterative_shifter_if.slave bus
);
    localparam int unsigned SHAMT_W = $clog2(WIDTH);
    localparam logic [SHAMT_W-1:0] STEP_AMT = SHAMT_W'(STEP);

    localparam logic [1:0] MODE_SLL  = 2'b00;
    localparam logic [1:0] MODE_SRL  = 2'b01;
    localparam logic [1:0] MODE_SRA  = 2'b10;
    localparam logic [1:0] MODE_ROTR = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_SHIFT = 2'b01,
        S_DONE  = 2'b10
    } state_e;

    state_e               state_q, state_d;
    logic [WIDTH-1:0]     acc_q, acc_d;
    logic [SHAMT_W-1:0]   rem_q, rem_d;
    logic [1:0]           mode_q, mode_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic [WIDTH-1:0]     num_out_q, num_out_d;

    logic [SHAMT_W-1:0]   step_s;
    logic [WIDTH-1:0]     acc_shift;
    logic [2*WIDTH-1:0]   rot_w;

    // One partial shift of at most STEP bits; the SRA sign survives in acc MSB.
    always_comb begin
        step_s    = (rem_q < STEP_AMT) ? rem_q : STEP_AMT;
        rot_w     = {acc_q, acc_q} >> step_s;
        acc_shift = acc_q;
        case (mode_q)
            MODE_SLL:  acc_shift = acc_q << step_s;
            MODE_SRL:  acc_shift = acc_q >> step_s;
            MODE_SRA:  acc_shift = $unsigned($signed(acc_q) >>> step_s);
            MODE_ROTR: acc_shift = rot_w[WIDTH-1:0];
            default:   acc_shift = acc_q;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        rem_d     = rem_q;
        mode_d    = mode_q;
        num_out_d = num_out_q;

        case (state_q)
            S_IDLE: begin
                if (bus.Start) begin
                    acc_d  = bus.NumIn;
                    rem_d  = bus.ShAmt;
                    mode_d = bus.Mode;
                    if (bus.ShAmt == '0) begin
                        state_d   = S_DONE;
                        num_out_d = bus.NumIn;
                    end else begin
                        state_d = S_SHIFT;
                    end
                end
            end
            S_SHIFT: begin
                acc_d = acc_shift;
                rem_d = rem_q - step_s;
                if (rem_q <= STEP_AMT) begin
                    state_d   = S_DONE;
                    num_out_d = acc_shift;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        busy_d = (state_d != S_IDLE);
        done_d = (state_d == S_DONE);
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q   <= S_IDLE;
            acc_q     <= '0;
            rem_q     <= '0;
            mode_q    <= MODE_SLL;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            num_out_q <= '0;
        end else begin
            state_q   <= state_d;
            acc_q     <= acc_d;
            rem_q     <= rem_d;
            mode_q    <= mode_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            num_out_q <= num_out_d;
        end
    end

    assign bus.Busy   = busy_q;
    assign bus.Done   = done_q;
    assign bus.NumOut = num_out_q;
endmodule

// File: tb/tb_iterative_shifter.sv
// Bench for iterative_shifter: three configurations (32/4, 32/8, 16/1) run in
// lockstep against a bit-level reference model, plus directed corner sequences.
module tb_iterative_shifter;
    logic        clk;
    logic        rst_n;
    logic        start_a, start_b, start_c;
    logic [31:0] num_in;
    logic [4:0]  sh_amt;
    logic [1:0]  mode;

    int checks;
    int errors;
    logic [31:0] prev_a, prev_b, prev_c;

    iterative_shifter_if #(.WIDTH(32)) if_a ();
    iterative_shifter_if #(.WIDTH(32)) if_b ();
    iterative_shifter_if #(.WIDTH(16)) if_c ();

    assign if_a.Start = start_a;
    assign if_a.NumIn = num_in;
    assign if_a.ShAmt = sh_amt;
    assign if_a.Mode  = mode;
    assign if_b.Start = start_b;
    assign if_b.NumIn = num_in;
    assign if_b.ShAmt = sh_amt;
    assign if_b.Mode  = mode;
    assign if_c.Start = start_c;
    assign if_c.NumIn = num_in[15:0];
    assign if_c.ShAmt = sh_amt[3:0];
    assign if_c.Mode  = mode;

    iterative_shifter #(.WIDTH(32), .STEP(4)) dut_a (.Clk(clk), .Rst_n(rst_n), .bus(if_a.slave));
    iterative_shifter #(.WIDTH(32), .STEP(8)) dut_b (.Clk(clk), .Rst_n(rst_n), .bus(if_b.slave));
    iterative_shifter #(.WIDTH(16), .STEP(1)) dut_c (.Clk(clk), .Rst_n(rst_n), .bus(if_c.slave));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] x;
        logic [4:0]  sh;
        logic [1:0]  md;
        logic        hold;
        logic [31:0] exp;
    } vec_t;

    vec_t tbl[12];

    // Each result bit picked from its source bit position, as the ISA defines it.
    function automatic logic [31:0] model(input logic [31:0] x, input int sh,
                                          input logic [1:0] md, input int w);
        logic [31:0] r;
        r = '0;
        for (int i = 0; i < w; i++) begin
            case (md)
                2'b00: r[i] = (i - sh >= 0) ? x[i-sh] : 1'b0;
                2'b01: r[i] = (i + sh < w) ? x[i+sh] : 1'b0;
                2'b10: r[i] = (i + sh < w) ? x[i+sh] : x[w-1];
                default: r[i] = x[(i+sh)%w];
            endcase
        end
        return r;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic check_dut(input string id, input int n, input int k, input logic busy,
                             input logic done, input logic [31:0] out,
                             input logic [31:0] exp, input logic [31:0] prev);
        chk($sformatf("%s busy n=%0d", id, n), {31'b0, busy}, 32'(n <= k + 1));
        chk($sformatf("%s done n=%0d", id, n), {31'b0, done}, 32'(n == k + 1));
        chk($sformatf("%s out n=%0d", id, n), out, (n >= k + 1) ? exp : prev);
    endtask

    task automatic set_start(input logic v);
        start_a = v;
        start_b = v;
        start_c = v;
    endtask

    // One operation on all three units; operands are scrambled right after capture.
    task automatic run_op(input logic [31:0] x, input logic [4:0] sh, input logic [1:0] md,
                          input logic hold, input logic [31:0] exp_a);
        int ka, kb, kc, kmax, shc;
        logic [31:0] exp_c;
        ka    = (int'(sh) + 3) / 4;
        kb    = (int'(sh) + 7) / 8;
        shc   = int'(sh[3:0]);
        kc    = shc;
        exp_c = model({16'h0, x[15:0]}, shc, md, 16);
        kmax  = (ka > kc) ? ka : kc;
        num_in = x;
        sh_amt = sh;
        mode   = md;
        set_start(1'b1);
        @(posedge clk); #1;
        if (!hold) set_start(1'b0);
        num_in = $urandom;
        sh_amt = 5'($urandom);
        mode   = 2'($urandom);
        for (int n = 1; n <= kmax + 2; n++) begin
            if (n > 1) begin
                @(posedge clk); #1;
            end
            if (n == 2) set_start(1'b0);
            check_dut("A", n, ka, if_a.Busy, if_a.Done, if_a.NumOut, exp_a, prev_a);
            check_dut("B", n, kb, if_b.Busy, if_b.Done, if_b.NumOut, exp_a, prev_b);
            check_dut("C", n, kc, if_c.Busy, if_c.Done, {16'h0, if_c.NumOut}, exp_c, prev_c);
        end
        prev_a = exp_a;
        prev_b = exp_a;
        prev_c = exp_c;
    endtask

    initial begin
        logic [31:0] rx;
        logic [4:0]  rs;
        logic [1:0]  rm;
        logic        exp_done, exp_busy;
        logic [31:0] exp_out;

        checks = 0;
        errors = 0;
        rst_n  = 1'b0;
        set_start(1'b0);
        num_in = '0;
        sh_amt = '0;
        mode   = '0;
        prev_a = '0;
        prev_b = '0;
        prev_c = '0;

        tbl[0]  = '{32'h00000001, 5'd2,  2'b00, 1'b0, 32'h00000004};
        tbl[1]  = '{32'h80000000, 5'd31, 2'b10, 1'b0, 32'hFFFFFFFF};
        tbl[2]  = '{32'h80000000, 5'd31, 2'b01, 1'b0, 32'h00000001};
        tbl[3]  = '{32'h12345678, 5'd8,  2'b11, 1'b0, 32'h78123456};
        tbl[4]  = '{32'hDEADBEEF, 5'd0,  2'b00, 1'b0, 32'hDEADBEEF};
        tbl[5]  = '{32'hDEADBEEF, 5'd0,  2'b01, 1'b1, 32'hDEADBEEF};
        tbl[6]  = '{32'hDEADBEEF, 5'd0,  2'b10, 1'b0, 32'hDEADBEEF};
        tbl[7]  = '{32'hDEADBEEF, 5'd0,  2'b11, 1'b1, 32'hDEADBEEF};
        tbl[8]  = '{32'h0000000F, 5'd5,  2'b00, 1'b1, 32'h000001E0};
        tbl[9]  = '{32'h00000001, 5'd31, 2'b11, 1'b0, 32'h00000002};
        tbl[10] = '{32'h7FFFFFFF, 5'd4,  2'b10, 1'b1, 32'h07FFFFFF};
        tbl[11] = '{32'hFFFFFFFF, 5'd31, 2'b00, 1'b0, 32'h80000000};

        repeat (2) @(posedge clk);
        #1;
        check_dut("A rst", 0, -2, if_a.Busy, if_a.Done, if_a.NumOut, 32'h0, 32'h0);
        check_dut("B rst", 0, -2, if_b.Busy, if_b.Done, if_b.NumOut, 32'h0, 32'h0);
        check_dut("C rst", 0, -2, if_c.Busy, if_c.Done, {16'h0, if_c.NumOut}, 32'h0, 32'h0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("A idle busy", {31'b0, if_a.Busy}, 32'h0);

        for (int i = 0; i < 12; i++)
            run_op(tbl[i].x, tbl[i].sh, tbl[i].md, tbl[i].hold, tbl[i].exp);

        // Start held high: SLL 1 then SRL 5, second accepted at the first IDLE edge.
        num_in  = 32'h00000001;
        sh_amt  = 5'd1;
        mode    = 2'b00;
        start_a = 1'b1;
        @(posedge clk); #1;
        num_in = 32'h000003E0;
        sh_amt = 5'd5;
        mode   = 2'b01;
        for (int n = 1; n <= 8; n++) begin
            if (n > 1) begin
                @(posedge clk); #1;
            end
            if (n == 4) start_a = 1'b0;
            exp_done = (n == 2) || (n == 6);
            exp_busy = (n <= 2) || (n >= 4 && n <= 6);
            exp_out  = (n < 2) ? prev_a : ((n < 6) ? 32'h00000002 : 32'h0000001F);
            chk($sformatf("b2b done n=%0d", n), {31'b0, if_a.Done}, {31'b0, exp_done});
            chk($sformatf("b2b busy n=%0d", n), {31'b0, if_a.Busy}, {31'b0, exp_busy});
            chk($sformatf("b2b out n=%0d", n), if_a.NumOut, exp_out);
        end
        prev_a = 32'h0000001F;

        // Reset asserted in the middle of a long shift.
        num_in = 32'h80000000;
        sh_amt = 5'd31;
        mode   = 2'b10;
        set_start(1'b1);
        @(posedge clk); #1;
        set_start(1'b0);
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        for (int n = 0; n < 3; n++) begin
            if (n > 0) begin
                @(posedge clk); #1;
            end
            check_dut("A midrst", n, -2, if_a.Busy, if_a.Done, if_a.NumOut, 32'h0, 32'h0);
            check_dut("B midrst", n, -2, if_b.Busy, if_b.Done, if_b.NumOut, 32'h0, 32'h0);
            check_dut("C midrst", n, -2, if_c.Busy, if_c.Done, {16'h0, if_c.NumOut}, 32'h0, 32'h0);
        end
        rst_n  = 1'b1;
        prev_a = '0;
        prev_b = '0;
        prev_c = '0;
        @(posedge clk); #1;
        run_op(32'h00000003, 5'd3, 2'b00, 1'b0, 32'h00000018);

        for (int i = 0; i < 40; i++) begin
            rx = $urandom;
            rs = 5'($urandom);
            rm = 2'($urandom);
            run_op(rx, rs, rm, 1'($urandom), model(rx, int'(rs), rm, 32));
            if ($urandom_range(0, 1) == 1) begin
                @(posedge clk); #1;
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
